// File: rtl/alu_bist_if.sv
// Operand/result and status bundle between the ALU BIST driver and its
// surroundings (ALU top on one side, board start button/LEDs on the other).
// master: the BIST driver. slave: the ALU plus board glue.
interface alu_bist_if #(
  parameter int WIDTH = 6
);
  logic                   start;
  logic [WIDTH-1:0]       alu_a;
  logic [WIDTH-1:0]       alu_b;
  logic [2:0]             alu_sel;
  logic [2*WIDTH-1:0]     alu_out;
  logic                   alu_overflow;
  logic                   busy;
  logic                   done;
  logic                   pass;
  logic [15:0]            err_count;
  logic [WIDTH-1:0]       fail_a;
  logic [WIDTH-1:0]       fail_b;
  logic [1:0]             fail_op;
  logic                   fail_valid;

  modport master (
    input  start, alu_out, alu_overflow,
    output alu_a, alu_b, alu_sel, busy, done, pass, err_count,
           fail_a, fail_b, fail_op, fail_valid
  );

  modport slave (
    output start, alu_out, alu_overflow,
    input  alu_a, alu_b, alu_sel, busy, done, pass, err_count,
           fail_a, fail_b, fail_op, fail_valid
  );
endinterface

// File: rtl/alu_bist_driver.sv
// ALU self-test engine: sweeps every signed (a,b) pair through add/sub/mul
// (and div), waits SETTLE cycles, checks the ALU against a golden model,
// counts mismatches and latches the first failing vector.
// Optional feature macro: ALU_BIST_DIV_EN -- when defined, div vectors
// (a>=0, b>0) are issued and checked; otherwise func=11 is never driven.
module alu_bist_driver #(
  parameter int   WIDTH  = 6,
  parameter int   SETTLE = 3,
  parameter logic CHOOSE = 1'b0
) (
  input  logic clk,
  input  logic rst,
  alu_bist_if.master bus
);
  localparam logic [WIDTH-1:0] LOWER = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] UPPER = {1'b0, {(WIDTH-1){1'b1}}};
  localparam int               CW    = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0]    WLOAD = CW'(SETTLE - 1);

  typedef enum logic [2:0] {S_IDLE, S_APPLY, S_WAIT, S_CHECK, S_DONE} state_t;

  state_t             state;
  logic [WIDTH-1:0]   i_q, j_q, a_q, b_q;
  logic [1:0]         op_q, func_q;
  logic [CW-1:0]      wcnt;
  logic               busy_q, done_q, pass_q, fv_q;
  logic [15:0]        err_q;
  logic [WIDTH-1:0]   fa_q, fb_q;
  logic [1:0]         fop_q;

  assign bus.alu_a      = a_q;
  assign bus.alu_b      = b_q;
  assign bus.alu_sel    = {CHOOSE, func_q};
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.pass       = pass_q;
  assign bus.err_count  = err_q;
  assign bus.fail_a     = fa_q;
  assign bus.fail_b     = fb_q;
  assign bus.fail_op    = fop_q;
  assign bus.fail_valid = fv_q;

  // Golden model: judged against the registered operands, which are stable in CHECK.
  logic [WIDTH:0]       sum;
  logic [2*WIDTH-1:0]   ax, bx, prod;
  logic                 ovf_exp, mismatch, div_ok, more_ops;
  logic [15:0]          err_nxt;
  always_comb begin
    sum      = '0;
    mismatch = 1'b0;
    ax       = {{WIDTH{a_q[WIDTH-1]}}, a_q};
    bx       = {{WIDTH{b_q[WIDTH-1]}}, b_q};
    prod     = ax * bx;
    if (func_q == 2'b01) sum = {a_q[WIDTH-1], a_q} - {b_q[WIDTH-1], b_q};
    else                 sum = {a_q[WIDTH-1], a_q} + {b_q[WIDTH-1], b_q};
    // out of range when the extra sign bit disagrees with the WIDTH-bit sign
    ovf_exp = sum[WIDTH] ^ sum[WIDTH-1];
    case (func_q)
      2'b00, 2'b01:
        mismatch = ovf_exp ? !bus.alu_overflow
                           : (bus.alu_overflow || (bus.alu_out[WIDTH-1:0] != sum[WIDTH-1:0]));
      2'b10: mismatch = (bus.alu_out != prod);
`ifdef ALU_BIST_DIV_EN
      // only issued with a>=0, b>0, so unsigned divide is exact
      2'b11: mismatch = (bus.alu_out[2*WIDTH-1:WIDTH] != (a_q / b_q)) ||
                        (bus.alu_out[WIDTH-1:0]       != (a_q % b_q));
`endif
      default: mismatch = 1'b0;
    endcase
    err_nxt = (mismatch && err_q != 16'hFFFF) ? err_q + 16'd1 : err_q;
`ifdef ALU_BIST_DIV_EN
    div_ok = !i_q[WIDTH-1] && !j_q[WIDTH-1] && (j_q != '0);
`else
    div_ok = 1'b0;
`endif
    // another op remains for the current (i,j) pair; skipped div costs no cycles
    more_ops = (op_q != 2'b11) && ((op_q != 2'b10) || div_ok);
  end

  // Sweep sequencer with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      i_q    <= '0;  j_q <= '0;  op_q <= '0;
      a_q    <= '0;  b_q <= '0;  func_q <= '0;
      wcnt   <= '0;
      busy_q <= 1'b0; done_q <= 1'b0; pass_q <= 1'b0;
      err_q  <= '0;
      fv_q   <= 1'b0; fa_q <= '0; fb_q <= '0; fop_q <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: if (bus.start) begin
          err_q  <= '0;
          fv_q   <= 1'b0; fa_q <= '0; fb_q <= '0; fop_q <= '0;
          i_q    <= LOWER; j_q <= LOWER; op_q <= 2'b00;
          busy_q <= 1'b1; done_q <= 1'b0; pass_q <= 1'b0;
          state  <= S_APPLY;
        end
        S_APPLY: begin
          a_q    <= i_q;
          b_q    <= j_q;
          func_q <= op_q;
          wcnt   <= WLOAD;
          state  <= S_WAIT;
        end
        S_WAIT: begin
          if (wcnt == '0) state <= S_CHECK;
          else            wcnt  <= wcnt - 1'b1;
        end
        S_CHECK: begin
          err_q <= err_nxt;
          if (mismatch && !fv_q) begin
            fv_q <= 1'b1; fa_q <= a_q; fb_q <= b_q; fop_q <= func_q;
          end
          if (more_ops) begin
            op_q  <= op_q + 2'd1;
            state <= S_APPLY;
          end else begin
            op_q <= 2'b00;
            if (j_q != UPPER) begin
              j_q   <= j_q + 1'b1;
              state <= S_APPLY;
            end else if (i_q != UPPER) begin
              i_q   <= i_q + 1'b1;
              j_q   <= LOWER;
              state <= S_APPLY;
            end else begin
              busy_q <= 1'b0;
              done_q <= 1'b1;
              pass_q <= (err_nxt == '0);
              state  <= S_DONE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: doc/alu_bist_driver.md
Name: alu_bist_driver

Overview:
- Hardware stimulus/check engine that drives the 6-bit signed ALU top (add/sub/mul/div) from the operand side and checks its results.
- Sweeps every signed operand pair through each operation, waits a settle time, compares against a built-in golden model, counts mismatches and captures the first failure.
- Sits between the board start button/LEDs and the ALU top for on-board self-test.

Parameters:
- WIDTH, 6: operand width. Signed range is -(2^(WIDTH-1)) .. 2^(WIDTH-1)-1.
- SETTLE, 3: idle cycles between applying operands and sampling the result (at least 1).
- CHOOSE, 0: constant driven on the select MSB (alu_sel[2]).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a sweep; sampled only in IDLE or DONE.
- alu_a  out  WIDTH  operand a to the ALU.
- alu_b  out  WIDTH  operand b to the ALU.
- alu_sel  out  3  {CHOOSE, func}, where func 00=add, 01=sub, 10=mul, 11=div.
- alu_out  in  2*WIDTH  ALU result.
- alu_overflow  in  1  ALU overflow flag.
- busy  out  1  sweep in progress.
- done  out  1  sweep complete; held until the next start or rst.
- pass  out  1  done and err_count==0.
- err_count  out  16  mismatch count, saturating at 16'hFFFF.
- fail_a  out  WIDTH  a of the first failing vector.
- fail_b  out  WIDTH  b of the first failing vector.
- fail_op  out  2  func of the first failing vector.
- fail_valid  out  1  a first failure has been captured.

Behaviour:
- Reset: state=IDLE. All outputs are 0: alu_a, alu_b, alu_sel[1:0], busy, done, pass, err_count, fail_*.
- States: IDLE -> APPLY -> WAIT -> CHECK -> (APPLY | DONE).
  - IDLE/DONE + start: clear err_count and fail_*, set i=j=LOWER, op=add, enter APPLY. busy goes high in the same cycle.
  - APPLY (1 cycle): register alu_a=i, alu_b=j, alu_sel={CHOOSE,op}.
  - WAIT: SETTLE cycles with operands held stable.
  - CHECK (1 cycle): sample alu_out and alu_overflow, evaluate, then advance.
  - Each vector therefore takes SETTLE+2 cycles.
- Iteration order: i outer loop ascending, j inner ascending, op innermost: add, sub, mul, then div.
- div is issued only when i>=0 and j>0 and ALU_BIST_DIV_EN is defined. Otherwise that op is skipped with zero cycles spent.
- After the last vector (i=j=UPPER, final applicable op): enter DONE with busy=0, done=1. The start-to-done latency is exactly 1+N*(SETTLE+2) cycles.
- Golden check, evaluated in CHECK:
  - add/sub: compute the exact sum or difference at WIDTH+1 bits.
    - Result out of range: pass iff alu_overflow=1. Low bits are don't-care.
    - Result in range: pass iff alu_overflow=0 and alu_out[WIDTH-1:0] equals the truncated result.
  - mul: pass iff alu_out equals the full signed 2*WIDTH product. Overflow is ignored.
  - div: pass iff alu_out[2W-1:W]==i/j and alu_out[W-1:0]==i%j (unsigned, since operands are non-negative).
- On a mismatch: err_count increments and saturates at FFFF, never wrapping. If fail_valid=0, capture fail_a, fail_b and fail_op and set fail_valid=1. Later failures never overwrite the capture.
- start while busy is ignored.
- start in DONE restarts a sweep: done drops the next cycle.
- rst asserted mid-sweep: return to IDLE next edge and clear all outputs. No partial results are retained.
- alu_a and alu_b change only in APPLY, so they never change during WAIT or CHECK.

Optional Feature:
- ALU_BIST_DIV_EN defined: div vectors are included. N=3*64*64+32*31=13280, giving 66400 cycles at SETTLE=3 (+1).
- Undefined: the div golden logic is not compiled and the func=11 code is never driven. N=12288, giving 61441 cycles.

Test Plan:
- Correct behavioural ALU, div enabled, SETTLE=3, pulse start -> done at exactly start+66401 cycles; pass=1, err_count=0, fail_valid=0.
- ALU model with the add overflow flag stuck at 0 -> err_count=1024 (add overflow pairs); fail_a=-32, fail_b=-32, fail_op=00.
- ALU model forcing alu_out=0 for mul -> err_count=3969 (all nonzero products); first failure -32, -32, op 10; pass=0.
- rst pulsed at cycle 5000 of a sweep -> next cycle busy=0, err_count=0, state IDLE. A following start completes a full clean sweep.
- start re-pulsed while busy at cycle 100 -> ignored; done timing unchanged. Build without ALU_BIST_DIV_EN -> alu_sel[1:0] never 11; done at start+61441 cycles.
